// File: rtl/ebpf_decode_stage.sv
// eBPF decode stage with per-thread LDDW pairing and halt tracking; registered control bundle.
// Latency 1 cycle; in_ready = !out_valid || out_ready (no skid), out_* hold while stalled.
module ebpf_decode_stage #(
  parameter int NUM_THREADS  = 4,
  parameter int TID_W        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  parameter bit ENABLE_JMP32 = 1'b0,
  parameter bit ENABLE_CALL  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_opcode,
  input  logic [TID_W-1:0]       in_tid,
  input  logic [NUM_THREADS-1:0] thread_restart,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TID_W-1:0]       out_tid,
  output logic                   out_regwrite,
  output logic                   out_memread,
  output logic                   out_memwrite,
  output logic                   out_memtoreg,
  output logic                   out_writesrc,
  output logic                   out_bit32,
  output logic [3:0]             out_alu_op,
  output logic [3:0]             out_branch,
  output logic [1:0]             out_alusrca,
  output logic [1:0]             out_alusrcb,
  output logic [1:0]             out_datasize,
  output logic [1:0]             out_imm_ext,
  output logic [1:0]             out_exc,
  output logic [NUM_THREADS-1:0] thread_halted
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LDDW_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;

  localparam logic [1:0] EXC_LDDW = 2'd1;
  localparam logic [1:0] EXC_EXIT = 2'd2;
  localparam logic [1:0] EXC_UNK  = 2'd3;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_MOV = 4'hB;
  localparam logic [3:0] OP_END = 4'hD;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       writesrc;
    logic       bit32;
    logic [3:0] alu_op;
    logic [3:0] branch;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] datasize;
    logic [1:0] imm_ext;
    logic [1:0] exc;
  } ctrl_t;

  logic [1:0]       thr_st [NUM_THREADS];
  logic [1:0]       cur_st;
  logic [1:0]       nxt_st;
  logic             accept;
  logic             legal;
  logic             jmp_legal;
  logic [2:0]       cls;
  logic [3:0]       op;
  logic             srcx;
  ctrl_t            dec;
  ctrl_t            nxt_bnd;
  ctrl_t            out_q;
  logic [TID_W-1:0] tid_q;
  logic             vld_q;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign cls  = in_opcode[2:0];
  assign op   = in_opcode[7:4];
  assign srcx = in_opcode[3];

  always_comb begin
    cur_st = ST_IDLE;
    for (int t = 0; t < NUM_THREADS; t++)
      if (in_tid == TID_W'(t)) cur_st = thr_st[t];
  end

  // JA, CALL and EXIT exist only in the 64-bit jump class with the immediate source encoding
  assign jmp_legal = ((op inside {[4'h1:4'h7], [4'hA:4'hD]}) && (cls == 3'd5 || ENABLE_JMP32)) ||
                     (cls == 3'd5 && !srcx &&
                      (op == 4'h0 || op == 4'h9 || (op == 4'h8 && ENABLE_CALL)));

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (cls)
      3'd4, 3'd7: begin
        if (op <= 4'hC || (cls == 3'd4 && op == OP_END)) begin
          legal        = 1'b1;
          dec.regwrite = 1'b1;
          dec.alu_op   = op;
          dec.alusrca  = (op == OP_MOV) ? 2'd2 : 2'd0;
          dec.alusrcb  = (srcx && op != OP_END) ? 2'd0 : 2'd1;
          dec.bit32    = (cls == 3'd4) && (op != OP_END);
        end
      end
      3'd0: begin
        if (in_opcode == 8'h18) begin
          legal        = 1'b1;
          dec.regwrite = 1'b1;
          dec.alu_op   = OP_MOV;
          dec.alusrca  = 2'd2;
          dec.alusrcb  = 2'd1;
          dec.datasize = 2'd3;
          dec.imm_ext  = 2'd1;
        end
      end
      3'd1: begin
        if (in_opcode[7:5] == 3'b011) begin
          legal        = 1'b1;
          dec.regwrite = 1'b1;
          dec.memread  = 1'b1;
          dec.memtoreg = 1'b1;
          dec.alusrca  = 2'd1;
          dec.alusrcb  = 2'd2;
          dec.datasize = in_opcode[4:3];
        end
      end
      3'd2, 3'd3: begin
        if (in_opcode[7:5] == 3'b011) begin
          legal        = 1'b1;
          dec.memwrite = 1'b1;
          dec.writesrc = (cls == 3'd3);
          dec.alusrcb  = 2'd2;
          dec.datasize = in_opcode[4:3];
        end
      end
      3'd5, 3'd6: begin
        if (jmp_legal) begin
          legal       = 1'b1;
          dec.branch  = op;
          dec.alu_op  = (op == 4'h0 || op == 4'h8 || op == 4'h9) ? OP_ADD : OP_SUB;
          dec.alusrcb = srcx ? 2'd0 : 2'd1;
          dec.bit32   = (cls == 3'd6);
        end
      end
    endcase
  end

  always_comb begin
    nxt_bnd = dec;
    nxt_st  = cur_st;
    case (cur_st)
      ST_LDDW_WAIT: begin
        if (in_opcode == 8'h00) begin
          nxt_bnd          = '0;
          nxt_bnd.regwrite = 1'b1;
          nxt_bnd.alu_op   = OP_OR;
          nxt_bnd.alusrcb  = 2'd1;
          nxt_bnd.datasize = 2'd3;
          nxt_bnd.imm_ext  = 2'd2;
          nxt_st           = ST_IDLE;
        end else begin
          nxt_bnd.exc = EXC_LDDW;
          nxt_st      = ST_HALTED;
        end
      end
      ST_IDLE: begin
        if (in_opcode == 8'h18) begin
          nxt_st = ST_LDDW_WAIT;
        end else if (in_opcode == 8'h95) begin
          nxt_bnd.exc = EXC_EXIT;
          nxt_st      = ST_HALTED;
        end else if (!legal) begin
          nxt_bnd.exc = EXC_UNK;
          nxt_st      = ST_HALTED;
        end
      end
      default: ;
    endcase
    // a faulting instruction must never commit architectural side effects
    if (nxt_bnd.exc != 2'd0) begin
      nxt_bnd.regwrite = 1'b0;
      nxt_bnd.memread  = 1'b0;
      nxt_bnd.memwrite = 1'b0;
      nxt_bnd.memtoreg = 1'b0;
      nxt_bnd.writesrc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      out_q <= '0;
      tid_q <= '0;
    end else if (accept && cur_st != ST_HALTED) begin
      vld_q <= 1'b1;
      out_q <= nxt_bnd;
      tid_q <= in_tid;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  // restart wins over the accept's transition, but the accept still decodes against the old state
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (!rst_n || thread_restart[t]) thr_st[t] <= ST_IDLE;
      else if (accept && in_tid == TID_W'(t)) thr_st[t] <= nxt_st;
    end
  end

  always_comb begin
    thread_halted = '0;
    for (int t = 0; t < NUM_THREADS; t++)
      thread_halted[t] = (thr_st[t] == ST_HALTED);
  end

  assign out_valid    = vld_q;
  assign out_tid      = tid_q;
  assign out_regwrite = out_q.regwrite;
  assign out_memread  = out_q.memread;
  assign out_memwrite = out_q.memwrite;
  assign out_memtoreg = out_q.memtoreg;
  assign out_writesrc = out_q.writesrc;
  assign out_bit32    = out_q.bit32;
  assign out_alu_op   = out_q.alu_op;
  assign out_branch   = out_q.branch;
  assign out_alusrca  = out_q.alusrca;
  assign out_alusrcb  = out_q.alusrcb;
  assign out_datasize = out_q.datasize;
  assign out_imm_ext  = out_q.imm_ext;
  assign out_exc      = out_q.exc;

endmodule

// File: tb/tb_ebpf_decode_stage.sv
// Bench for ebpf_decode_stage: instance 0 has JMP32/CALL disabled, instance 1 enabled;
// a table-driven opcode model plus per-thread state lists predicts every bundle.
module tb_ebpf_decode_stage;

  localparam int K_ILL = 0, K_ALU32 = 1, K_ALU64 = 2, K_SWAP = 3, K_LDDW = 4, K_LDX = 5,
                 K_ST = 6, K_STX = 7, K_JA = 8, K_JC = 9, K_JC32 = 10, K_CALL = 11, K_EXIT = 12;
  localparam int S_IDLE = 0, S_WAIT = 1, S_HALT = 2;

  typedef struct packed {
    logic [1:0] tid;
    logic rw, mr, mw, mtr, ws, b32;
    logic [3:0] alu, br;
    logic [1:0] sa, sb, ds, ie, exc;
  } bnd_t;

  logic clk, rst_n;
  logic       iv [2];
  logic [7:0] opc [2];
  logic [1:0] tid [2];
  logic [3:0] rthr [2];
  logic       ordy [2];

  logic       ir [2], ov [2], orw [2], omr [2], omw [2], omtr [2], ows [2], ob32 [2];
  logic [1:0] otid [2], osa [2], osb [2], ods [2], oie [2], oexc [2];
  logic [3:0] oalu [2], obr [2], ohalt [2];

  int   kind [2][256];
  int   m_st [2][4];
  bit   m_vld [2];
  bnd_t m_b [2];
  bit   armed;
  logic [7:0] hot [24];
  int   n_tests, n_fail;

  ebpf_decode_stage #(.NUM_THREADS(4), .ENABLE_JMP32(1'b0), .ENABLE_CALL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_opcode(opc[0]),
    .in_tid(tid[0]), .thread_restart(rthr[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_tid(otid[0]), .out_regwrite(orw[0]), .out_memread(omr[0]), .out_memwrite(omw[0]),
    .out_memtoreg(omtr[0]), .out_writesrc(ows[0]), .out_bit32(ob32[0]), .out_alu_op(oalu[0]),
    .out_branch(obr[0]), .out_alusrca(osa[0]), .out_alusrcb(osb[0]), .out_datasize(ods[0]),
    .out_imm_ext(oie[0]), .out_exc(oexc[0]), .thread_halted(ohalt[0]));

  ebpf_decode_stage #(.NUM_THREADS(4), .ENABLE_JMP32(1'b1), .ENABLE_CALL(1'b1)) dut_en (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_opcode(opc[1]),
    .in_tid(tid[1]), .thread_restart(rthr[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_tid(otid[1]), .out_regwrite(orw[1]), .out_memread(omr[1]), .out_memwrite(omw[1]),
    .out_memtoreg(omtr[1]), .out_writesrc(ows[1]), .out_bit32(ob32[1]), .out_alu_op(oalu[1]),
    .out_branch(obr[1]), .out_alusrca(osa[1]), .out_alusrcb(osb[1]), .out_datasize(ods[1]),
    .out_imm_ext(oie[1]), .out_exc(oexc[1]), .thread_halted(ohalt[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic build_tables();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) kind[k][i] = K_ILL;
      for (int op = 0; op <= 12; op++)
        for (int s = 0; s < 2; s++) begin
          kind[k][op*16 + s*8 + 4] = K_ALU32;
          kind[k][op*16 + s*8 + 7] = K_ALU64;
        end
      kind[k][8'hd4] = K_SWAP;
      kind[k][8'hdc] = K_SWAP;
      kind[k][8'h18] = K_LDDW;
      for (int z = 0; z < 4; z++) begin
        kind[k][8'h61 + 8*z] = K_LDX;
        kind[k][8'h62 + 8*z] = K_ST;
        kind[k][8'h63 + 8*z] = K_STX;
      end
      kind[k][8'h05] = K_JA;
      for (int op = 1; op <= 13; op++)
        if (op <= 7 || op >= 10)
          for (int s = 0; s < 2; s++) begin
            kind[k][op*16 + s*8 + 5] = K_JC;
            if (k == 1) kind[k][op*16 + s*8 + 6] = K_JC32;
          end
      if (k == 1) kind[k][8'h85] = K_CALL;
      kind[k][8'h95] = K_EXIT;
    end
  endtask

  function automatic bnd_t tmpl(input int k, input logic [7:0] o);
    bnd_t b;
    int   hi, sz;
    b  = '0;
    hi = int'(o) / 16;
    sz = (int'(o & 8'hF8) - 'h60) / 8;
    case (kind[k][o])
      K_ALU32, K_ALU64: begin
        b.rw = 1; b.alu = 4'(hi); b.sa = (hi == 11) ? 2'd2 : 2'd0;
        b.sb = o[3] ? 2'd0 : 2'd1; b.b32 = (kind[k][o] == K_ALU32);
      end
      K_SWAP: begin b.rw = 1; b.alu = 4'hD; b.sb = 1; end
      K_LDDW: begin b.rw = 1; b.alu = 4'hB; b.sa = 2; b.sb = 1; b.ds = 3; b.ie = 1; end
      K_LDX:  begin b.rw = 1; b.mr = 1; b.mtr = 1; b.sa = 1; b.sb = 2; b.ds = 2'(sz); end
      K_ST:   begin b.mw = 1; b.sb = 2; b.ds = 2'(sz); end
      K_STX:  begin b.mw = 1; b.ws = 1; b.sb = 2; b.ds = 2'(sz); end
      K_JA:   begin b.sb = 1; end
      K_CALL: begin b.br = 4'h8; b.sb = 1; end
      K_EXIT: begin b.br = 4'h9; b.sb = 1; end
      K_JC, K_JC32: begin
        b.br = 4'(hi); b.alu = 4'h1; b.sb = o[3] ? 2'd0 : 2'd1; b.b32 = (kind[k][o] == K_JC32);
      end
      default: ;
    endcase
    return b;
  endfunction

  task automatic mstep(input int k, input int s, input logic [7:0] o, output bnd_t b, output int ns);
    b  = tmpl(k, o);
    ns = s;
    if (s == S_WAIT) begin
      if (o == 8'h00) begin
        b = '0; b.rw = 1; b.alu = 4'h4; b.sb = 1; b.ds = 3; b.ie = 2; ns = S_IDLE;
      end else begin
        b.exc = 1; ns = S_HALT;
      end
    end else if (o == 8'h18) ns = S_WAIT;
    else if (o == 8'h95) begin b.exc = 2; ns = S_HALT; end
    else if (kind[k][o] == K_ILL) begin b.exc = 3; ns = S_HALT; end
    if (b.exc != 0) begin b.rw = 0; b.mr = 0; b.mw = 0; b.mtr = 0; b.ws = 0; end
  endtask

  always @(posedge clk) begin
    bit   acc;
    bnd_t b;
    int   ns, s;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_vld[k] = 0; m_b[k] = '0; armed = 1;
        for (int t = 0; t < 4; t++) m_st[k][t] = S_IDLE;
      end else begin
        acc = iv[k] && (!m_vld[k] || ordy[k]);
        if (acc) begin
          s = m_st[k][tid[k]];
          if (s != S_HALT) begin
            mstep(k, s, opc[k], b, ns);
            b.tid = tid[k];
            m_b[k] = b; m_vld[k] = 1; m_st[k][tid[k]] = ns;
          end else if (ordy[k]) m_vld[k] = 0;
        end else if (ordy[k]) m_vld[k] = 0;
        for (int t = 0; t < 4; t++) if (rthr[k][t]) m_st[k][t] = S_IDLE;
      end
    end
  end

  always @(negedge clk) begin
    bnd_t act;
    logic [3:0] eh;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        for (int t = 0; t < 4; t++) eh[t] = (m_st[k][t] == S_HALT);
        n_tests++;
        if (ov[k] !== m_vld[k]) begin
          n_fail++; $display("FAIL out_valid[%0d] t=%0t got %b want %b", k, $time, ov[k], m_vld[k]);
        end
        n_tests++;
        if (ir[k] !== (!m_vld[k] || ordy[k])) begin
          n_fail++; $display("FAIL in_ready[%0d] t=%0t got %b want %b", k, $time, ir[k], !m_vld[k] || ordy[k]);
        end
        n_tests++;
        if (ohalt[k] !== eh) begin
          n_fail++; $display("FAIL halted[%0d] t=%0t got %b want %b", k, $time, ohalt[k], eh);
        end
        if (m_vld[k]) begin
          act = {otid[k], orw[k], omr[k], omw[k], omtr[k], ows[k], ob32[k], oalu[k], obr[k],
                 osa[k], osb[k], ods[k], oie[k], oexc[k]};
          n_tests++;
          if (act !== m_b[k]) begin
            n_fail++; $display("FAIL bundle[%0d] t=%0t got %h want %h", k, $time, act, m_b[k]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++; $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input bit [1:0] km, input logic [7:0] o, input logic [1:0] t, input logic [3:0] rs);
    for (int k = 0; k < 2; k++)
      if (km[k]) begin iv[k] = 1; opc[k] = o; tid[k] = t; rthr[k] = rs; end
    tick();
    for (int k = 0; k < 2; k++) begin iv[k] = 0; rthr[k] = 0; end
  endtask

  task automatic restart(input logic [3:0] rs);
    rthr[0] = rs; rthr[1] = rs;
    tick();
    rthr[0] = 0; rthr[1] = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; armed = 0;
    build_tables();
    hot = '{8'h18, 8'h00, 8'h95, 8'h07, 8'h0f, 8'hb7, 8'hbf, 8'hd4, 8'hdc, 8'hd7, 8'h61, 8'h7b,
            8'h62, 8'h73, 8'h05, 8'h15, 8'h7d, 8'ha5, 8'hdd, 8'h16, 8'hde, 8'h85, 8'h8d, 8'he5};
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin iv[k] = 0; opc[k] = 0; tid[k] = 0; rthr[k] = 0; ordy[k] = 1; end
    tick(); tick();
    chk("rst_valid", int'(ov[0]), 0);
    chk("rst_ready", int'(ir[0]), 1);
    chk("rst_halted", int'(ohalt[0]), 0);
    chk("rst_exc", int'(oexc[0]), 0);
    rst_n = 1;

    send(2'b01, 8'h18, 0, 0);
    chk("lddw1_imm_ext", int'(oie[0]), 1);
    chk("lddw1_alu", int'(oalu[0]), 'hB);
    chk("lddw1_exc", int'(oexc[0]), 0);
    send(2'b01, 8'h00, 0, 0);
    chk("lddw2_imm_ext", int'(oie[0]), 2);
    chk("lddw2_alu", int'(oalu[0]), 4);
    chk("lddw2_exc", int'(oexc[0]), 0);
    chk("lddw2_idle", int'(ohalt[0][0]), 0);

    send(2'b01, 8'h18, 1, 0);
    send(2'b01, 8'h07, 1, 0);
    chk("intr_exc", int'(oexc[0]), 1);
    chk("intr_halted", int'(ohalt[0][1]), 1);
    chk("intr_regwrite", int'(orw[0]), 0);
    send(2'b01, 8'h07, 1, 0);
    chk("halt_drop", int'(ov[0]), 0);
    restart(4'b0010);
    chk("restart_clear", int'(ohalt[0][1]), 0);
    send(2'b01, 8'h07, 1, 0);
    chk("after_restart_exc", int'(oexc[0]), 0);
    chk("after_restart_rw", int'(orw[0]), 1);

    send(2'b01, 8'h18, 0, 0);
    send(2'b01, 8'h95, 2, 0);
    chk("exit_exc", int'(oexc[0]), 2);
    chk("exit_halted", int'(ohalt[0][2]), 1);
    send(2'b01, 8'h00, 0, 0);
    chk("inter_exc", int'(oexc[0]), 0);
    chk("inter_imm_ext", int'(oie[0]), 2);
    chk("inter_tid", int'(otid[0]), 0);
    restart(4'b0100);

    send(2'b01, 8'h00, 3, 0);
    chk("stray_exc", int'(oexc[0]), 3);
    send(2'b01, 8'h07, 3, 4'b1000);
    chk("rs_acc_drop", int'(ov[0]), 0);
    chk("rs_acc_idle", int'(ohalt[0][3]), 0);
    send(2'b01, 8'h18, 0, 0);
    send(2'b01, 8'h07, 0, 4'b0001);
    chk("rs_wait_exc", int'(oexc[0]), 1);
    chk("rs_wait_idle", int'(ohalt[0][0]), 0);

    send(2'b01, 8'h18, 1, 0);
    rst_n = 0; tick(); rst_n = 1;
    send(2'b01, 8'h00, 1, 0);
    chk("rst_mid_lddw", int'(oexc[0]), 3);
    restart(4'hF);

    send(2'b11, 8'h16, 0, 0);
    chk("jmp32_off_exc", int'(oexc[0]), 3);
    chk("jmp32_on_exc", int'(oexc[1]), 0);
    chk("jmp32_on_branch", int'(obr[1]), 1);
    chk("jmp32_on_bit32", int'(ob32[1]), 1);
    send(2'b11, 8'h85, 1, 0);
    chk("call_off_exc", int'(oexc[0]), 3);
    chk("call_on_exc", int'(oexc[1]), 0);
    chk("call_on_branch", int'(obr[1]), 8);
    restart(4'hF);

    ordy[0] = 0; iv[0] = 1; opc[0] = 8'h27; tid[0] = 0;
    tick();
    opc[0] = 8'h37;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", int'(ir[0]), 0);
      chk("bp_hold", int'(oalu[0]), 2);
      tick();
    end
    ordy[0] = 1;
    tick();
    chk("bp_next", int'(oalu[0]), 3);
    iv[0] = 0;
    tick();

    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        opc[k]  = ($urandom_range(0, 1) == 0) ? hot[$urandom_range(0, 23)] : 8'($urandom);
        tid[k]  = 2'($urandom_range(0, 3));
        rthr[k] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      rst_n = (c % 1500 != 1499);
      tick();
    end
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin iv[k] = 0; ordy[k] = 1; rthr[k] = 0; end
    tick(); tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
